// File: rtl/ecc_sed_pkg.sv
// Shared constants and buffer-state encoding for the single-error-detect parity path.
// The encoder stage and the checker both import this package.
package ecc_sed_pkg;

    localparam int DATA_W = 12;
    localparam int CW_W   = DATA_W + 1;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Even parity: the top bit makes the XOR over the whole codeword zero.
    function automatic logic [CW_W-1:0] sed_encode(input logic [DATA_W-1:0] data);
        return {^data, data};
    endfunction

endpackage

// File: rtl/ecc_sed_skid_buf.sv
// Two-entry in-order buffer with a registered write-side ready.
//   state     | meaning
//   BUF_EMPTY | no entry held, rd_valid low
//   BUF_ONE   | head valid, tail free
//   BUF_FULL  | head and tail valid, wr_ready low
module ecc_sed_skid_buf
    import ecc_sed_pkg::*;
#(
    parameter int W = CW_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    buf_state_t   state, state_nxt;
    logic [W-1:0] head, head_nxt;
    logic [W-1:0] tail, tail_nxt;
    logic         ready_q;
    logic         push, pop;

    assign push = wr_valid & ready_q;
    assign pop  = rd_valid & rd_ready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            BUF_EMPTY: begin
                if (push) begin
                    state_nxt = BUF_ONE;
                    head_nxt  = wr_data;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    head_nxt = wr_data;
                end else if (push) begin
                    state_nxt = BUF_FULL;
                    tail_nxt  = wr_data;
                end else if (pop) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    state_nxt = BUF_ONE;
                    head_nxt  = tail;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    // Ready is precomputed from the next state so it comes straight off a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BUF_EMPTY;
            head    <= '0;
            tail    <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            head    <= head_nxt;
            tail    <= tail_nxt;
            ready_q <= (state_nxt != BUF_FULL);
        end
    end

    assign wr_ready = ready_q;
    assign rd_valid = (state != BUF_EMPTY);
    assign rd_data  = head;

endmodule

// File: rtl/ecc_sed_checker.sv
// Parity checker: computes the codeword syndrome, buffers {data, syndrome}
// in a two-entry buffer and keeps a saturating count of erroneous accepts.
module ecc_sed_checker #(
    parameter int DATA_W = ecc_sed_pkg::DATA_W,
    parameter int CNT_W  = ecc_sed_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W:0]   enc_codeword,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
);

    localparam int CW_W = DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            syndrome;
    logic            accept;
    logic            acc_err;
    logic [CW_W-1:0] buf_wr;
    logic [CW_W-1:0] buf_rd;

    assign syndrome = ^enc_codeword;
    assign accept   = enc_valid & enc_ready;
    assign acc_err  = accept & syndrome;
    assign buf_wr   = {enc_codeword[DATA_W-1:0], syndrome};

    ecc_sed_skid_buf #(
        .W(CW_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (enc_valid),
        .wr_ready (enc_ready),
        .wr_data  (buf_wr),
        .rd_valid (dec_valid),
        .rd_ready (dec_ready),
        .rd_data  (buf_rd)
    );

    assign dec_data = buf_rd[CW_W-1:1];
    assign dec_err  = buf_rd[0];

    // A clear coinciding with an erroneous accept still counts that accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= CNT_W'(acc_err);
        end else if (acc_err && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Self-checking bench for ecc_sed_checker: queue-based reference model,
// per-cycle compare process, directed literal scenarios and random traffic.
module tb_ecc_sed_checker;

    localparam int DATA_W  = 12;
    localparam int CNT_W   = 8;
    localparam int CW_W    = DATA_W + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enc_valid = 1'b0;
    logic              enc_ready;
    logic [CW_W-1:0]   enc_codeword = '0;
    logic              dec_valid;
    logic              dec_ready = 1'b0;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    ecc_sed_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_valid    (enc_valid),
        .enc_ready    (enc_ready),
        .enc_codeword (enc_codeword),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_data     (dec_data),
        .dec_err      (dec_err),
        .err_cnt      (err_cnt),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CW_W-1:0] m_q[$];   // entries {err, data}
    int              m_cnt   = 0;
    bit              m_ready = 1'b0;

    function automatic bit odd_ones(input logic [CW_W-1:0] cw);
        int ones = 0;
        for (int i = 0; i < CW_W; i++) ones += int'(cw[i]);
        return (ones % 2) == 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit acc, pop, e;
        if (!rst) begin
            m_q.delete();
            m_cnt   = 0;
            m_ready = 1'b0;
        end else begin
            acc = enc_valid && m_ready;
            pop = dec_ready && (m_q.size() > 0);
            e   = odd_ones(enc_codeword);
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back({e, enc_codeword[DATA_W-1:0]});
            if (err_clr)                          m_cnt = (acc && e) ? 1 : 0;
            else if (acc && e && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            m_ready = (m_q.size() < 2);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [CW_W-1:0] hd;
        check("enc_ready", enc_ready, m_ready);
        check("dec_valid", dec_valid, m_q.size() > 0);
        check("err_cnt", err_cnt, m_cnt);
        if (m_q.size() > 0) begin
            hd = m_q[0];
            check("dec_data", dec_data, hd[DATA_W-1:0]);
            check("dec_err", dec_err, hd[DATA_W]);
        end
        if (!rst) begin
            check("rst_dec_data", dec_data, 0);
            check("rst_dec_err", dec_err, 0);
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [CW_W-1:0] cw, input bit rdy, input bit clr);
        enc_valid    = v;
        enc_codeword = cw;
        dec_ready    = rdy;
        err_clr      = clr;
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("lit_rst_valid", dec_valid, 0);
        check("lit_rst_ready", enc_ready, 0);
        check("lit_rst_cnt", err_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        check("lit_ready_rise", enc_ready, 1);

        // clean word, one cycle latency
        step(1'b1, 13'h0A5C, 1'b1, 1'b0);
        check("lit_a5c_valid", dec_valid, 1);
        check("lit_a5c_data", dec_data, 12'hA5C);
        check("lit_a5c_err", dec_err, 0);
        check("lit_a5c_cnt", err_cnt, 0);

        // two erroneous words
        step(1'b1, 13'h1A5C, 1'b1, 1'b0);
        check("lit_1a5c_err", dec_err, 1);
        step(1'b1, 13'h1FFF, 1'b1, 1'b0);
        check("lit_1fff_data", dec_data, 12'hFFF);
        check("lit_1fff_err", dec_err, 1);
        check("lit_cnt2", err_cnt, 2);
        step(1'b0, '0, 1'b1, 1'b0);

        // back-pressure: fill, hold third word, drain in order
        step(1'b1, 13'h0123, 1'b0, 1'b0);
        step(1'b1, 13'h0456, 1'b0, 1'b0);
        check("lit_full_ready", enc_ready, 0);
        check("lit_full_head", dec_data, 12'h123);
        step(1'b1, 13'h0789, 1'b0, 1'b0);
        check("lit_held_head", dec_data, 12'h123);
        check("lit_held_ready", enc_ready, 0);
        step(1'b1, 13'h0789, 1'b1, 1'b0);
        check("lit_pop1_head", dec_data, 12'h456);
        check("lit_pop1_err", dec_err, 1);
        step(1'b1, 13'h0789, 1'b1, 1'b0);
        check("lit_pushpop_valid", dec_valid, 1);
        check("lit_pushpop_head", dec_data, 12'h789);
        step(1'b0, '0, 1'b1, 1'b0);
        check("lit_drained", dec_valid, 0);

        // saturation and clear
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 13'h1000, 1'b1, 1'b0);
        check("lit_sat", err_cnt, 255);
        step(1'b1, 13'h1000, 1'b1, 1'b1);
        check("lit_clr_err", err_cnt, 1);
        step(1'b0, '0, 1'b1, 1'b1);
        check("lit_clr_only", err_cnt, 0);

        // random traffic
        for (int i = 0; i < 2000; i++)
            step(($urandom % 4) != 0, CW_W'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);

        // reset while full
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 13'h1000, 1'b0, 1'b0);
        step(1'b1, 13'h0123, 1'b0, 1'b0);
        check("lit_prerst_ready", enc_ready, 0);
        check("lit_prerst_valid", dec_valid, 1);
        enc_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("lit_rst_full_valid", dec_valid, 0);
        check("lit_rst_full_cnt", err_cnt, 0);
        check("lit_rst_full_ready", enc_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("lit_no_stale", dec_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ecc_sed_checker.md
ECC_SED_CHECKER -- requirements
Module: ecc_sed_checker

Interface
REQ-001 Parameter: DATA_W, default 12, payload width; codeword width is DATA_W+1.
REQ-002 Parameter: CNT_W, default 8, error-counter width.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: enc_valid  input  1  codeword offered by the encoder stage.
REQ-006 Port: enc_ready  output  1  checker can accept a codeword this cycle.
REQ-007 Port: enc_codeword  input  DATA_W+1  {parity, data}; the parity bit is the XOR of all data bits (even parity).
REQ-008 Port: dec_valid  output  1  checked word available.
REQ-009 Port: dec_ready  input  1  consumer takes the word.
REQ-010 Port: dec_data  output  DATA_W  payload of the head entry.
REQ-011 Port: dec_err  output  1  parity mismatch flag of the head entry.
REQ-012 Port: err_cnt  output  CNT_W  saturating count of accepted erroneous codewords.
REQ-013 Port: err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-014 Syndrome SHALL be the XOR of all DATA_W+1 codeword bits; a value of 1 means error.
REQ-015 Accept SHALL occur when enc_valid and enc_ready are both high; pop SHALL occur when dec_valid and dec_ready are both high.
REQ-016 The checker SHALL buffer {data, syndrome} in a 2-entry in-order buffer with states EMPTY, ONE and FULL.
REQ-017 enc_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL be driven from registers only.
REQ-018 dec_valid SHALL be 1 in ONE and FULL; dec_data and dec_err SHALL come from the head entry.
REQ-019 Latency SHALL be exactly 1 cycle: a word accepted at edge N is visible at dec_* after edge N.
REQ-020 Transitions SHALL be as follows:
- EMPTY + push -> ONE
- ONE + push without pop -> FULL
- ONE + pop without push -> EMPTY
- ONE + push and pop -> ONE, with the new word at the head
- FULL + pop -> ONE
REQ-021 While dec_valid=1 and dec_ready=0, dec_data and dec_err SHALL remain stable.
REQ-022 err_cnt SHALL increment on each accept with syndrome 1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 err_clr in the same cycle as an erroneous accept SHALL load err_cnt with 1; err_clr alone SHALL load 0.
REQ-024 Accepts are never dropped: a word offered in FULL SHALL wait until enc_ready is 1.

Reset
REQ-025 While rst=0, the buffer SHALL be EMPTY, dec_valid=0, enc_ready=0, dec_data=0, dec_err=0 and err_cnt=0.
REQ-026 enc_ready SHALL rise on the first clk edge after rst is released.
REQ-027 Reset mid-transfer SHALL discard all buffered words with no partial output.

Structure
REQ-028 Shared package ecc_sed_pkg SHALL hold DATA_W, CW_W (=DATA_W+1), CNT_W and the buffer-state enum; the encoder stage SHALL use the same package.
REQ-029 The 2-entry buffer SHALL be one sub-module, ecc_sed_skid_buf, parameterised on entry width; syndrome and counter logic SHALL live in the top.

Verification
REQ-030 Scenario: enc_codeword=0x0A5C, dec_ready=1 -> one cycle later dec_valid=1, dec_data=0xA5C, dec_err=0, err_cnt=0.
REQ-031 Scenario: enc_codeword=0x1A5C, then 0x1FFF -> dec_err=1 for both; err_cnt reads 2.
REQ-032 Scenario: dec_ready=0, three back-to-back valid words -> enc_ready falls after two accepts, the third word is held, and all three later emerge in order when dec_ready=1.
REQ-033 Scenario: 300 erroneous words with CNT_W=8 -> err_cnt stops at 255; err_clr with an erroneous accept gives 1, and err_clr alone gives 0.
REQ-034 Scenario: rst asserted while FULL -> dec_valid=0 and err_cnt=0 immediately, and no stale word appears after release.
REQ-035 Scenario: in ONE, push and pop in the same cycle -> remains ONE and the output shows the new word with no bubble.
